mcpu_alu_sequencer: RTL
=======================

Name: mcpu_alu_sequencer

Overview:
Micro-sequencer that fetches 8-bit ALU instructions from an external instruction port and decodes them. It reads operands from a local 4-entry register file, drives the shared MCPU ALU (opcode, r1, r2), and writes results back. It also keeps a sticky overflow flag. It sits between the program source and the combinational MCPU ALU, one instruction in flight at a time.

Parameters:
CMD_SIZE, 2, ALU opcode width (AND=0, OR=1, XOR=2, ADD=3).
WORD_SIZE, 4, data word width, passed to the ALU and the register file.
ADDR_W, 4, program counter / instruction address width.

Ports:
clk  input  1  single clock, rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  pulse; begins execution of instr_count instructions from address 0.
instr_count  input  ADDR_W+1  number of instructions to run; latched on accepted start.
busy  output  1  high from accepted start until done.
done  output  1  one-cycle pulse at end of run.
instr_req  output  1  fetch request.
instr_addr  output  ADDR_W  fetch address (PC).
instr_ack  input  1  fetch acknowledge; instr_data valid in the same cycle.
instr_data  input  CMD_SIZE+6  instruction: [7:6] op, [5:4] rd, [3:2] rs1, [1:0] rs2.
alu_opcode  output  CMD_SIZE  to ALU opcode.
alu_r1  output  WORD_SIZE  to ALU operand 1.
alu_r2  output  WORD_SIZE  to ALU operand 2.
alu_out  input  WORD_SIZE  ALU result.
alu_overflow  input  1  ALU carry-out.
cfg_we  input  1  register preload write enable (honoured only in IDLE).
cfg_addr  input  2  register preload / readback index.
cfg_wdata  input  WORD_SIZE  preload data.
cfg_rdata  output  WORD_SIZE  combinational readback of reg[cfg_addr].
ovf_flag  output  1  sticky overflow flag.

Behaviour:
- Reset (synchronous): state IDLE; PC=0; remaining count=0; all regs 0; ovf_flag=0; busy=0, done=0, instr_req=0; alu_opcode/alu_r1/alu_r2=0.
- States: IDLE, FETCH, DECODE, EXEC, WB, DONE.
- IDLE:
  - start=1 latches instr_count, sets PC=0, clears ovf_flag, busy=1.
  - Goes to FETCH, or to DONE if instr_count=0.
  - cfg_we writes reg[cfg_addr] in IDLE only. If cfg_we and start occur in the same cycle, both take effect.
- FETCH:
  - instr_req=1 and instr_addr=PC, held stable until instr_ack.
  - On ack, latch instr_data and go to DECODE. Wait states are unlimited.
- DECODE: latch op, rd, reg[rs1], reg[rs2] into operand registers.
- EXEC: alu_opcode/alu_r1/alu_r2 driven from the latched operands (registered outputs, stable the whole cycle); ALU settles.
- WB:
  - reg[rd] <= alu_out.
  - If op==ADD and alu_overflow=1, ovf_flag <= 1 (sticky; never cleared by logical ops).
  - PC <= PC+1, wrapping modulo 2^ADDR_W. Count decrements.
  - Goes to FETCH if remaining >0, else DONE.
- DONE: done=1 for exactly one cycle, busy=0 next cycle, return to IDLE.
- Throughput: 4 cycles per instruction when ack arrives in the first FETCH cycle.
- Hazards:
  - rd may equal rs1/rs2: operands are captured in DECODE, so old values are used.
  - Back-to-back dependent instructions see the prior WB result, because WB completes before the next DECODE.
- start while busy: ignored. cfg_we while busy: ignored (no write).
- Count 16 with ADDR_W=4: PC wraps 15->0 after the last instruction; no fault.
- Reset mid-run (any state): back to IDLE next edge, regs cleared, no done pulse, instr_req drops immediately.
- cfg_rdata is valid in any state; it is the intended debug/verification readback.

Decomposition:
- Package mcpu_pkg holds:
  - CMD_AND/OR/XOR/ADD opcode constants.
  - State enumeration.
  - Instruction field positions (OP_MSB/LSB, RD, RS1, RS2).
- Sub-module mcpu_regfile: 4 x WORD_SIZE, one write port, two read ports for DECODE plus one read port for cfg readback, synchronous reset.
- The sequencer muxes the write port between cfg (IDLE) and WB.

Test Plan:
1. Preload r1=5, r2=3; instr[0]=0xC6 (ADD r0=r1+r2); start, count=1, ack immediate.
   -> done exactly 5 cycles after start; r0=8, ovf_flag=0.
2. Preload r1=9, r2=8; ADD r3=r1+r2 (0xF6).
   -> r3=1, ovf_flag=1. Then a second run with XOR r0=r1^r2 (0x86) -> r0=1, ovf_flag=0 (cleared by start).
3. Program AND r0=r1&r2 (0x06), OR r2=r0|r1 (0x61) with r1=0xC, r2=0xA, count=2.
   -> r0=0x8, r2=0xC; result forwarded via regfile.
4. instr_ack delayed 3 cycles on each fetch.
   -> instr_addr/instr_req stable during the wait; results identical to scenario 1; run takes 8 cycles.
5. count=0 -> done pulse in the cycle after start, no instr_req. count=16 -> instr_addr sequence 0..15, PC returns to 0.
6. Assert reset during EXEC of a 3-instruction run.
   -> IDLE next cycle, all regs 0, no done. Also: start and cfg_we while busy -> no effect.

Source files
------------

// File: rtl/mcpu_pkg.sv
// Shared definitions for the MCPU ALU sequencer: opcodes, sequencer states and
// instruction field positions.
package mcpu_pkg;

  typedef enum logic [1:0] {
    CMD_AND = 2'd0,
    CMD_OR  = 2'd1,
    CMD_XOR = 2'd2,
    CMD_ADD = 2'd3
  } alu_cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_DONE
  } seq_state_t;

  localparam int unsigned REG_COUNT = 4;
  localparam int unsigned REG_IDX_W = 2;

  // Instruction layout: {op, rd, rs1, rs2}; op occupies the top CMD_SIZE bits.
  localparam int unsigned RS2_LSB = 0;
  localparam int unsigned RS2_MSB = 1;
  localparam int unsigned RS1_LSB = 2;
  localparam int unsigned RS1_MSB = 3;
  localparam int unsigned RD_LSB  = 4;
  localparam int unsigned RD_MSB  = 5;
  localparam int unsigned OP_LSB  = 6;

endpackage

// File: rtl/mcpu_regfile.sv
// 4-entry register file: one write port, two operand read ports and one
// debug/preload readback port. Synchronous active-high reset.
module mcpu_regfile
  import mcpu_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic [REG_IDX_W-1:0] raddr_a,
  input  logic [REG_IDX_W-1:0] raddr_b,
  input  logic [REG_IDX_W-1:0] raddr_c,
  output logic [WORD_SIZE-1:0] rdata_a,
  output logic [WORD_SIZE-1:0] rdata_b,
  output logic [WORD_SIZE-1:0] rdata_c
);

  logic [WORD_SIZE-1:0] regs [REG_COUNT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
  assign rdata_c = regs[raddr_c];

endmodule

// File: rtl/mcpu_alu_sequencer.sv
// Micro-sequencer: fetches 8-bit ALU instructions, reads operands from a local
// register file, drives the external combinational ALU and writes results back.
module mcpu_alu_sequencer
  import mcpu_pkg::*;
#(
  parameter int unsigned CMD_SIZE  = 2,
  parameter int unsigned WORD_SIZE = 4,
  parameter int unsigned ADDR_W    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W:0]       instr_count,
  output logic                  busy,
  output logic                  done,
  output logic                  instr_req,
  output logic [ADDR_W-1:0]     instr_addr,
  input  logic                  instr_ack,
  input  logic [CMD_SIZE+5:0]   instr_data,
  output logic [CMD_SIZE-1:0]   alu_opcode,
  output logic [WORD_SIZE-1:0]  alu_r1,
  output logic [WORD_SIZE-1:0]  alu_r2,
  input  logic [WORD_SIZE-1:0]  alu_out,
  input  logic                  alu_overflow,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_addr,
  input  logic [WORD_SIZE-1:0]  cfg_wdata,
  output logic [WORD_SIZE-1:0]  cfg_rdata,
  output logic                  ovf_flag
);

  localparam int unsigned INSTR_W = CMD_SIZE + 6;
  localparam int unsigned CNT_W   = ADDR_W + 1;

  seq_state_t           state;
  logic [ADDR_W-1:0]    pc;
  logic [CNT_W-1:0]     remaining;
  logic [INSTR_W-1:0]   instr_q;
  logic [REG_IDX_W-1:0] rd_q;

  logic                 rf_we;
  logic [REG_IDX_W-1:0] rf_waddr;
  logic [WORD_SIZE-1:0] rf_wdata;
  logic [WORD_SIZE-1:0] rs1_data;
  logic [WORD_SIZE-1:0] rs2_data;

  // Single write port: write-back owns it in WB, preload only while idle.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = cfg_addr;
    rf_wdata = cfg_wdata;
    if (state == S_WB) begin
      rf_we    = 1'b1;
      rf_waddr = rd_q;
      rf_wdata = alu_out;
    end else if (state == S_IDLE && cfg_we) begin
      rf_we = 1'b1;
    end
  end

  mcpu_regfile #(
    .WORD_SIZE (WORD_SIZE)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (instr_q[RS1_MSB:RS1_LSB]),
    .raddr_b (instr_q[RS2_MSB:RS2_LSB]),
    .raddr_c (cfg_addr),
    .rdata_a (rs1_data),
    .rdata_b (rs2_data),
    .rdata_c (cfg_rdata)
  );

  assign instr_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      pc         <= '0;
      remaining  <= '0;
      instr_q    <= '0;
      rd_q       <= '0;
      ovf_flag   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      instr_req  <= 1'b0;
      alu_opcode <= '0;
      alu_r1     <= '0;
      alu_r2     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            remaining <= instr_count;
            pc        <= '0;
            ovf_flag  <= 1'b0;
            busy      <= 1'b1;
            if (instr_count == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state     <= S_FETCH;
              instr_req <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (instr_ack) begin
            instr_q   <= instr_data;
            instr_req <= 1'b0;
            state     <= S_DECODE;
          end
        end
        S_DECODE: begin
          // Operands are captured here, so rd==rs reads the pre-write value.
          alu_opcode <= instr_q[OP_LSB +: CMD_SIZE];
          alu_r1     <= rs1_data;
          alu_r2     <= rs2_data;
          rd_q       <= instr_q[RD_MSB:RD_LSB];
          state      <= S_EXEC;
        end
        S_EXEC: begin
          state <= S_WB;
        end
        S_WB: begin
          if (alu_opcode == CMD_SIZE'(CMD_ADD) && alu_overflow) begin
            ovf_flag <= 1'b1;
          end
          pc        <= pc + ADDR_W'(1);
          remaining <= remaining - CNT_W'(1);
          if (remaining > CNT_W'(1)) begin
            state     <= S_FETCH;
            instr_req <= 1'b1;
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
